// File: rtl/fp_mul_iter.sv
// ---------------------------------------------------------------------------
// fp_mul_iter : iterative shift-add IEEE-754-style multiplier, RNE rounding
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_mul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(SW);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic            sign;
  logic            nan_any, inf_a, inf_b, zero_a, zero_b;
  logic [EW-1:0]   exp_sum;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   mcand;
  logic [SW-1:0]   mplier;
  logic [CW-1:0]   cnt;

  // Operand field decode
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_exp_ones, b_exp_ones, a_exp_zero, b_exp_zero;
  logic [SW-1:0]    sig_a, sig_b;

  always_comb begin
    a_exp      = a[W-2:MAN_W];
    b_exp      = b[W-2:MAN_W];
    a_frac     = a[MAN_W-1:0];
    b_frac     = b[MAN_W-1:0];
    a_exp_ones = &a_exp;
    b_exp_ones = &b_exp;
    a_exp_zero = ~|a_exp;
    b_exp_zero = ~|b_exp;
    sig_a      = a_exp_zero ? '0 : {1'b1, a_frac};
    sig_b      = b_exp_zero ? '0 : {1'b1, b_frac};
  end

  // Normalise, round and resolve specials
  logic             msb, guard, sticky, round_up, ovf, unf;
  logic [PW-2:0]    norm;
  logic [MAN_W-1:0] frac_t, frac_o;
  logic [MAN_W+1:0] sig_r;
  logic [EW-1:0]    exp_f;
  logic [W-1:0]     res;
  logic [3:0]       flg;

  always_comb begin
    msb      = prod[PW-1];
    norm     = msb ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    frac_t   = norm[PW-2 -: MAN_W];
    guard    = norm[PW-2-MAN_W];
    sticky   = |norm[PW-3-MAN_W:0];
    round_up = guard & (sticky | frac_t[0]);
    sig_r    = {1'b0, 1'b1, frac_t} + {{(MAN_W+1){1'b0}}, round_up};
    frac_o   = sig_r[MAN_W+1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    exp_f    = exp_sum + EW'(msb) + EW'(sig_r[MAN_W+1]);
    // exp_f is two's complement; the top bit marks a negative exponent
    ovf      = !exp_f[EW-1] && (exp_f >= {2'b00, {EXP_W{1'b1}}});
    unf      = exp_f[EW-1] || (exp_f == '0);
    res      = {sign, exp_f[EXP_W-1:0], frac_o};
    flg      = {3'b000, guard | sticky};
    if (nan_any || (inf_a && zero_b) || (inf_b && zero_a)) begin
      res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg = 4'b1000;
    end else if (inf_a || inf_b) begin
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 4'b0000;
    end else if (zero_a || zero_b) begin
      res = {sign, {(W-1){1'b0}}};
      flg = 4'b0000;
    end else if (ovf) begin
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 4'b0101;
    end else if (unf) begin
      res = {sign, {(W-1){1'b0}}};
      flg = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= a[W-1] ^ b[W-1];
            nan_any  <= (a_exp_ones && |a_frac) || (b_exp_ones && |b_frac);
            inf_a    <= a_exp_ones && ~|a_frac;
            inf_b    <= b_exp_ones && ~|b_frac;
            zero_a   <= a_exp_zero;
            zero_b   <= b_exp_zero;
            exp_sum  <= EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
            prod     <= '0;
            mcand    <= {{SW{1'b0}}, sig_a};
            mplier   <= sig_b;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MAN_W)) state <= NORM;
        end
        NORM: begin
          out       <= res;
          flags     <= flg;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_iter.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_iter : self-checking bench for fp_mul_iter (default widths)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] a, b, out;
  logic [3:0]  flags;
  int          checks = 0;
  int          failures = 0;

  localparam int LAT = 25;

  always #5 clk = ~clk;

  fp_mul_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );

  logic [31:0] dir_a [0:6] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F000000,
                               32'h00800000, 32'h7F800000, 32'hFF800000};
  logic [31:0] dir_b [0:6] = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h40000000,
                               32'h3F000000, 32'h00000000, 32'h40000000};
  logic [31:0] dir_r [0:6] = '{32'h40400000, 32'hBF800000, 32'h3F800002, 32'h7F800000,
                               32'h00000000, 32'h7FC00000, 32'hFF800000};
  logic [3:0]  dir_f [0:6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0101,
                               4'b0011, 4'b1000, 4'b0000};

  // Reference: exact integer product, then round-to-nearest-even by remainder
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f);
    int     ex, ey, e, sh;
    longint p, q, rem, half;
    logic   s, nx, ny, ix, iy, zx, zy;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    if (nx || ny || (ix && zy) || (iy && zx)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (ix || iy) begin
      r = {s, 8'hFF, 23'h0}; f = 4'b0000;
    end else if (zx || zy) begin
      r = {s, 31'h0}; f = 4'b0000;
    end else begin
      p = ((longint'(1) << 23) + longint'(x[22:0])) * ((longint'(1) << 23) + longint'(y[22:0]));
      e = ex + ey - 127;
      if (p >= (longint'(1) << 47)) begin sh = 24; e++; end
      else sh = 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0011;
      end else begin
        r = {s, e[7:0], q[22:0]}; f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  ex;
    logic [22:0] fr;
    int          cls;
    cls = int'($urandom_range(0, 15));
    fr  = 23'($urandom);
    case (cls)
      0:       ex = 8'h00;
      1: begin ex = 8'hFF; if ($urandom_range(0, 1) == 0) fr = '0; end
      2:       ex = 8'($urandom_range(1, 20));
      3:       ex = 8'($urandom_range(235, 254));
      default: ex = 8'($urandom_range(60, 194));
    endcase
    return {1'($urandom), ex, fr};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    r = out; f = flags;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", out); end
    checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_op(dir_a[i], dir_b[i], r, f, lat);
      checks++; if (r !== dir_r[i]) begin failures++; $display("FAIL directed_out[%0d] got=%h exp=%h", i, r, dir_r[i]); end
      checks++; if (f !== dir_f[i]) begin failures++; $display("FAIL directed_flags[%0d] got=%b exp=%b", i, f, dir_f[i]); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, r, er;
    logic [3:0]  f, ef;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      x = rand_op();
      y = rand_op();
      ref_mul(x, y, er, ef);
      run_op(x, y, r, f, lat);
      checks++; if (r !== er || f !== ef || lat != LAT) begin
        failures++;
        $display("FAIL random[%0d] a=%h b=%h got=%h/%b/%0d exp=%h/%b/%0d", i, x, y, r, f, lat, er, ef, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t_prev, n_seen, t;
    t_prev = -1; n_seen = 0;
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
    for (t = 0; t < 200 && n_seen < 3; t++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        checks++; if (out !== 32'h40400000) begin failures++; $display("FAIL b2b_out got=%h exp=40400000", out); end
        if (t_prev >= 0) begin
          checks++; if (t - t_prev != 27) begin failures++; $display("FAIL b2b_interval got=%0d exp=27", t - t_prev); end
        end
        t_prev = t; n_seen++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n_seen != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n_seen); end
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic seen;
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1 a = 32'h3F800000; b = 32'h3F800000;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (out !== 32'h40400000 || flags !== 4'h0) begin
        failures++; $display("FAIL bp_hold[%0d] got=%h/%b exp=40400000/0000", i, out, flags);
      end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hs[%0d] got in_ready=%b out_valid=%b exp 0/1", i, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1 seen |= out_valid; end
    checks++; if (seen !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_no_capture got seen=%b in_ready=%b exp 0/1", seen, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic        seen;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_state got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1 seen |= out_valid; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_discard got=%b exp=0", seen); end
    run_op(32'h3FC00000, 32'h40000000, r, f, lat);
    checks++; if (r !== 32'h40400000 || f !== 4'h0 || lat != LAT) begin
      failures++; $display("FAIL midrst_fresh got=%h/%b/%0d exp=40400000/0000/%0d", r, f, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
